// File: rtl/clk_reset_pkg.sv
// Shared constants for the DCM / reset-domain sequencer: state encoding,
// counter width and the saturating counter step.
package clk_reset_pkg;

  localparam int CNT_W = 24;

  localparam logic [2:0] ASSERT_RST = 3'd0;
  localparam logic [2:0] WAIT_LOCK  = 3'd1;
  localparam logic [2:0] SETTLE     = 3'd2;
  localparam logic [2:0] RELEASE    = 3'd3;
  localparam logic [2:0] RUN        = 3'd4;
  localparam logic [2:0] FAIL       = 3'd5;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_sat_inc(input cnt_t c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/dcm_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the rest of the chip.
interface dcm_reset_sequencer_if #(
  parameter int STAGES      = 3,
  parameter int MAX_RETRIES = 3
);
  localparam int RC_W = $clog2(MAX_RETRIES + 1);

  logic              dcmLocked;
  logic              softReset;
  logic              dcmReset;
  logic [STAGES-1:0] domainReset;
  logic              ready;
  logic              failed;
  logic [RC_W-1:0]   retryCount;

  modport master (
    input  dcmLocked, softReset,
    output dcmReset, domainReset, ready, failed, retryCount
  );

  modport slave (
    output dcmLocked, softReset,
    input  dcmReset, domainReset, ready, failed, retryCount
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Power-up sequencer: pulses DCM reset, waits for lock (with retries), lets
// lock settle, then releases the reset domains one at a time, index 0 first.
module dcm_reset_sequencer
  import clk_reset_pkg::*;
#(
  parameter int DCM_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int SETTLE_CYCLES  = 65535,
  parameter int STAGES         = 3,
  parameter int STAGE_DELAY    = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                  clk,
  input  logic                  resetN,
  dcm_reset_sequencer_if.master bus
);

  localparam int   RC_W        = $clog2(MAX_RETRIES + 1);
  localparam cnt_t RST_LAST    = cnt_t'(DCM_RST_CYCLES - 1);
  localparam cnt_t TO_LAST     = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);
  localparam cnt_t STAGE_LAST  = cnt_t'(STAGE_DELAY - 1);

  logic              w_lockS;
  logic              w_softS;
  logic              w_lockLoss;
  logic [STAGES-1:0] w_domNext;

  logic [2:0]        r_state;
  cnt_t              r_cnt;
  logic              r_dcmReset;
  logic [STAGES-1:0] r_dom;
  logic              r_ready;
  logic              r_failed;
  logic [RC_W-1:0]   r_retry;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .rst_n (resetN),
    .i_d   (bus.dcmLocked),
    .o_q   (w_lockS)
  );

  sync_2ff u_sync_soft (
    .clk   (clk),
    .rst_n (resetN),
    .i_d   (bus.softReset),
    .o_q   (w_softS)
  );

  // Lock only matters once we have committed to it; earlier states ignore it.
  assign w_lockLoss = !w_lockS &&
                      (r_state == SETTLE || r_state == RELEASE || r_state == RUN);

  // Shifting in zeros from the bottom keeps domainReset in the 1..10..0 form.
  assign w_domNext = r_dom << 1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ASSERT_RST;
      r_cnt      <= '0;
      r_dcmReset <= 1'b1;
      r_dom      <= '1;
      r_ready    <= 1'b0;
      r_failed   <= 1'b0;
      r_retry    <= '0;
    end else if (w_softS) begin
      r_state    <= ASSERT_RST;
      r_cnt      <= '0;
      r_dcmReset <= 1'b1;
      r_dom      <= '1;
      r_ready    <= 1'b0;
      r_failed   <= 1'b0;
      r_retry    <= '0;
    end else if (w_lockLoss) begin
      r_state    <= ASSERT_RST;
      r_cnt      <= '0;
      r_dcmReset <= 1'b1;
      r_dom      <= '1;
      r_ready    <= 1'b0;
    end else begin
      r_cnt <= cnt_sat_inc(r_cnt);
      case (r_state)
        ASSERT_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_dcmReset <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (w_lockS) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_cnt <= '0;
            if (r_retry == RC_W'(MAX_RETRIES)) begin
              r_state  <= FAIL;
              r_failed <= 1'b1;
            end else begin
              r_state    <= ASSERT_RST;
              r_retry    <= r_retry + 1'b1;
              r_dcmReset <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= RELEASE;
            r_cnt   <= '0;
          end
        end
        RELEASE: begin
          if (r_cnt == STAGE_LAST) begin
            r_cnt <= '0;
            r_dom <= w_domNext;
            if (w_domNext == '0) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end
          end
        end
        RUN, FAIL: begin
        end
        default: begin
          r_state    <= ASSERT_RST;
          r_cnt      <= '0;
          r_dcmReset <= 1'b1;
          r_dom      <= '1;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dcmReset    = r_dcmReset;
  assign bus.domainReset = r_dom;
  assign bus.ready       = r_ready;
  assign bus.failed      = r_failed;
  assign bus.retryCount  = r_retry;

endmodule
